// File: rtl/fxy_checker_if.sv
// Handshake and result bundle for the NOR-gate checker.
// FXY_CHECKER_FAIL_CAPTURE_EN adds the first-failure capture signals.
interface fxy_checker_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic             x;
  logic             y;
  logic             s;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic [3:0]       coverage;
`ifdef FXY_CHECKER_FAIL_CAPTURE_EN
  logic [2:0]       first_fail;
  logic             first_fail_vld;

  modport master (
    output start, in_valid, x, y, s,
    input  in_ready, busy, done, pass, pass_cnt, fail_cnt, coverage,
    input  first_fail, first_fail_vld
  );
  modport slave (
    input  start, in_valid, x, y, s,
    output in_ready, busy, done, pass, pass_cnt, fail_cnt, coverage,
    output first_fail, first_fail_vld
  );
`else
  modport master (
    output start, in_valid, x, y, s,
    input  in_ready, busy, done, pass, pass_cnt, fail_cnt, coverage
  );
  modport slave (
    input  start, in_valid, x, y, s,
    output in_ready, busy, done, pass, pass_cnt, fail_cnt, coverage
  );
`endif
endinterface

// File: rtl/fxy_checker.sv
// Checks observed NOR results against their operands, counting hits and misses
// until all four operand combinations are seen. Option: FXY_CHECKER_FAIL_CAPTURE_EN.
module fxy_checker #(
  parameter int CNT_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  fxy_checker_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic [3:0]       cov_q, cov_d;
  logic             accept;
  logic             match;
  logic [1:0]       combo;
`ifdef FXY_CHECKER_FAIL_CAPTURE_EN
  logic [2:0]       first_fail_q, first_fail_d;
  logic             first_fail_vld_q, first_fail_vld_d;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign accept = (state_q == RUN) && bus.in_valid;
  assign combo  = {bus.x, bus.y};
  assign match  = (bus.s == (~bus.x & ~bus.y));

  always_comb begin
    state_d    = state_q;
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    cov_d      = cov_q;
`ifdef FXY_CHECKER_FAIL_CAPTURE_EN
    first_fail_d     = first_fail_q;
    first_fail_vld_d = first_fail_vld_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        // A new pass starts from a clean slate; samples in this cycle are dropped.
        if (bus.start) begin
          state_d    = RUN;
          pass_cnt_d = '0;
          fail_cnt_d = '0;
          cov_d      = '0;
`ifdef FXY_CHECKER_FAIL_CAPTURE_EN
          first_fail_d     = '0;
          first_fail_vld_d = 1'b0;
`endif
        end
      end
      RUN: begin
        if (accept) begin
          if (match) begin
            pass_cnt_d = sat_inc(pass_cnt_q);
          end else begin
            fail_cnt_d = sat_inc(fail_cnt_q);
`ifdef FXY_CHECKER_FAIL_CAPTURE_EN
            if (!first_fail_vld_q) begin
              first_fail_d     = {bus.x, bus.y, bus.s};
              first_fail_vld_d = 1'b1;
            end
`endif
          end
          cov_d = cov_q | (4'b0001 << combo);
          if (cov_d == 4'b1111) begin
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
    pass_d = done_d && (fail_cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      cov_q      <= '0;
`ifdef FXY_CHECKER_FAIL_CAPTURE_EN
      first_fail_q     <= '0;
      first_fail_vld_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      cov_q      <= cov_d;
`ifdef FXY_CHECKER_FAIL_CAPTURE_EN
      first_fail_q     <= first_fail_d;
      first_fail_vld_q <= first_fail_vld_d;
`endif
    end
  end

  assign bus.in_ready = busy_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.pass_cnt = pass_cnt_q;
  assign bus.fail_cnt = fail_cnt_q;
  assign bus.coverage = cov_q;
`ifdef FXY_CHECKER_FAIL_CAPTURE_EN
  assign bus.first_fail     = first_fail_q;
  assign bus.first_fail_vld = first_fail_vld_q;
`endif

endmodule
